// File: rtl/mult5_seq_ctrl_pkg.sv
// Shared constants, state encoding and early-exit helpers for the 5x5 sequential multiplier.
// The helpers are only referenced when MULT5_EARLY_EXIT_EN is defined.
package mult5_seq_ctrl_pkg;

  localparam int WIDTH  = 5;
  localparam int ITER   = 5;
  localparam int PROD_W = 10;
  localparam int ACC_W  = 11;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Mask of multiplier bits still unconsumed in lo after the iteration with index cnt.
  function automatic logic [WIDTH-1:0] rem_mask(input logic [CNT_W-1:0] cnt);
    logic [WIDTH-1:0] m;
    m = '0;
    case (cnt)
      3'd0:    m = 5'b01111;
      3'd1:    m = 5'b00111;
      3'd2:    m = 5'b00011;
      3'd3:    m = 5'b00001;
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

  // Remaining shifts (ITER-1-cnt) once the iteration with index cnt has been applied.
  function automatic logic [CNT_W-1:0] rem_shift(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] s;
    s = '0;
    case (cnt)
      3'd0:    s = 3'd4;
      3'd1:    s = 3'd3;
      3'd2:    s = 3'd2;
      3'd3:    s = 3'd1;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fivebit_adder.sv
// 5-bit ripple adder with carry in/out; the only arithmetic shared by the multiplier.
module fivebit_adder (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       cin,
  output logic [4:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {5'b00000, cin};

endmodule

// File: rtl/mult5_seq_ctrl.sv
// Sequential 5x5 shift-and-add multiplier controller built around one shared fivebit_adder.
// Optional MULT5_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
// Handshake: start is sampled only in IDLE; done is a one-cycle strobe and product holds until the next done.
module mult5_seq_ctrl
  import mult5_seq_ctrl_pkg::*;
#(
  parameter int P_WIDTH = WIDTH,
  parameter int P_ITER  = ITER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product,
  output logic [1:0]        dbg_state_o
);

  if (P_WIDTH != 5 || P_ITER != P_WIDTH) begin : g_bad_param
    $error("mult5_seq_ctrl supports only WIDTH=ITER=5");
  end

  state_e              state_q;
  logic [WIDTH-1:0]    mcand_q;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PROD_W-1:0]   product_q;
  logic                busy_q;
  logic                done_q;

  logic [WIDTH-1:0]    add_sum;
  logic                add_cout;
  logic [ACC_W-1:0]    acc_step;
  logic [ACC_W-1:0]    acc_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                last_d;
  logic [PROD_W-1:0]   product_d;

  fivebit_adder u_adder (
    .a    (acc_q[9:5]),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // acc_q[10] is always zero after a shift, so the no-add path can reuse acc_q directly.
  always_comb begin
    acc_step = acc_q[0] ? {add_cout, add_sum, acc_q[4:0]} : acc_q;
    acc_d    = acc_step >> 1;
    cnt_d    = cnt_q + 3'd1;
`ifdef MULT5_EARLY_EXIT_EN
    last_d    = (cnt_q == CNT_W'(ITER - 1)) || ((acc_d[4:0] & rem_mask(cnt_q)) == '0);
    product_d = PROD_W'(acc_d >> rem_shift(cnt_q));
`else
    last_d    = (cnt_q == CNT_W'(ITER - 1));
    product_d = acc_d[PROD_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q <= a;
            acc_q   <= {6'b000000, b};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (last_d) begin
            product_q <= product_d;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign product     = product_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult5_seq_ctrl.sv
// Self-checking bench for mult5_seq_ctrl: latency, holding, back-to-back, ignore, mid-run reset, full sweep.
module tb_mult5_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] a;
  logic [4:0] b;
  logic       busy;
  logic       done;
  logic [9:0] product;
  logic [1:0] dbg_state;

  int checks;
  int errors;
  logic [9:0] exp_q[$];

  mult5_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every done strobe must consume one expected product.
  always @(negedge clk) begin
    if (!reset && done) begin
      logic [9:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done product=%0d (no result expected)", product);
      end else begin
        e = exp_q.pop_front();
        if (product !== e) begin
          errors++;
          $display("FAIL product got=%0d exp=%0d", product, e);
        end
      end
    end
  end

  function automatic int exp_latency(input logic [4:0] bv);
    int runs;
    runs = 1;
    for (int k = 0; k < 5; k++) if (bv[k]) runs = k + 1;
`ifdef MULT5_EARLY_EXIT_EN
    return runs + 1;
`else
    return (runs > 0) ? 6 : 0;
`endif
  endfunction

  task automatic start_op(input logic [4:0] av, input logic [4:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 5'($urandom_range(0, 31));
    b = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      errors++;
      checks++;
      $display("FAIL done_timeout got=none exp=done within 30 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    if (product !== 10'd0) begin errors++; $display("FAIL reset_product got=%0d exp=0", product); end
  endtask

  task automatic test_basic();
    int lat, bc;
    exp_q.push_back(10'd143);
    start_op(5'd13, 5'd11);
    wait_done(lat, bc);
    checks += 2;
    if (lat !== exp_latency(5'd11)) begin
      errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, exp_latency(5'd11));
    end
    if (bc !== exp_latency(5'd11)) begin
      errors++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, exp_latency(5'd11));
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
  endtask

  task automatic test_hold_product();
    int lat, bc;
    logic held_ok;
    exp_q.push_back(10'd961);
    start_op(5'd31, 5'd31);
    wait_done(lat, bc);
    exp_q.push_back(10'd0);
    start_op(5'd0, 5'd25);
    held_ok = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) break;
      if (product !== 10'd961) held_ok = 1'b0;
    end
    checks++;
    if (held_ok !== 1'b1) begin errors++; $display("FAIL hold_product got=changed exp=961 held"); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    exp_q.push_back(10'd30);
    @(negedge clk);
    a = 5'd5;
    b = 5'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 5'd7;
    b = 5'd9;
    wait_done(lat, bc);
    exp_q.push_back(10'd63);
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap got=busy%b/done%b exp=busy0/done0", busy, done);
    end
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL b2b_idle_state got=%0d exp=0", dbg_state);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    checks++;
    if (lat !== exp_latency(5'd9)) begin
      errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, exp_latency(5'd9));
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    exp_q.push_back(10'd260);
    start_op(5'd20, 5'd13);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (i <= 2) begin
        start = 1'b1;
        a = 5'd9;
        b = 5'd9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (lat !== exp_latency(5'd13)) begin
      errors++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, exp_latency(5'd13));
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    start_op(5'd21, 5'd17);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got=%b exp=0", done); end
    if (product !== 10'd0) begin errors++; $display("FAIL midreset_product got=%0d exp=0", product); end
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL midreset_quiet got=activity exp=idle"); end
  endtask

  task automatic test_early();
    int lat, bc;
    exp_q.push_back(10'd31);
    start_op(5'd31, 5'd1);
    wait_done(lat, bc);
    checks++;
    if (lat !== exp_latency(5'd1)) begin
      errors++; $display("FAIL early_b1_latency got=%0d exp=%0d", lat, exp_latency(5'd1));
    end
    exp_q.push_back(10'd496);
    start_op(5'd31, 5'd16);
    wait_done(lat, bc);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL early_b16_latency got=%0d exp=6", lat); end
  endtask

  task automatic test_sweep();
    int lat, bc, bad_lat;
    bad_lat = 0;
    for (int ai = 0; ai < 32; ai++) begin
      for (int bi = 0; bi < 32; bi++) begin
        exp_q.push_back(10'(ai * bi));
        start_op(5'(ai), 5'(bi));
        wait_done(lat, bc);
        if (lat !== exp_latency(5'(bi))) bad_lat++;
      end
    end
    checks++;
    if (bad_lat !== 0) begin errors++; $display("FAIL sweep_latency got=%0d wrong exp=0 wrong", bad_lat); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_hold_product();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_early();
    test_sweep();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
